// File: rtl/cache_port_scheduler_pkg.sv
// Shared types and bank helper for the cache port scheduler.
// Bank select is a fixed slice of the word address above BANK_OFFSET.
package cache_sched_pkg;

    localparam int ADDR_WIDTH  = 30;
    localparam int DATA_WIDTH  = 32;
    localparam int TAG_WIDTH   = 4;
    localparam int NUM_BANKS   = 4;
    localparam int BANK_OFFSET = 0;
    localparam int WMASK_WIDTH = DATA_WIDTH / 8;
    localparam int BANK_BITS   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef logic [BANK_BITS-1:0] BankIdx;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  wdata;
        logic [WMASK_WIDTH-1:0] wmask;
        logic [TAG_WIDTH-1:0]   tag;
    } CacheReq_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } CacheResp_t;

    typedef struct packed {
        logic                   ce;
        logic                   we;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  data;
        logic [WMASK_WIDTH-1:0] wmask;
    } CacheIF_t;

    // A single-bank configuration masks the slice down to zero.
    function automatic BankIdx bank_of(input logic [ADDR_WIDTH-1:0] addr);
        return BankIdx'(addr >> BANK_OFFSET) & BankIdx'(NUM_BANKS - 1);
    endfunction

endpackage

// File: rtl/cache_port_scheduler_if.sv
// Requester and arbiter facing signals of the cache port scheduler.
// slave is the scheduler side; master is the environment (requesters + arbiter).
interface cache_port_scheduler_if #(
    parameter int NUM_PORTS = 4
);
    import cache_sched_pkg::*;

    logic                  IN_flush;
    CacheReq_t             IN_req       [NUM_PORTS];
    logic [NUM_PORTS-1:0]  OUT_reqReady;
    CacheIF_t              OUT_ports    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  IN_portReady;
    logic [DATA_WIDTH-1:0] IN_portRData [NUM_PORTS];
    CacheResp_t            OUT_resp     [NUM_PORTS];

    modport slave (
        input  IN_flush, IN_req, IN_portReady, IN_portRData,
        output OUT_reqReady, OUT_ports, OUT_resp
    );

    modport master (
        output IN_flush, IN_req, IN_portReady, IN_portRData,
        input  OUT_reqReady, OUT_ports, OUT_resp
    );

endinterface

// File: rtl/cache_port_scheduler_starve_select.sv
// Per-port starvation credit and sticky urgent-winner register.
// Masks the winner's same-bank competitors until the winner is granted.
module starve_select
    import cache_sched_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic [NUM_PORTS-1:0] i_slot_valid,
    input  logic [NUM_PORTS-1:0] i_grant,
    input  BankIdx               i_bank [NUM_PORTS],
    output logic [NUM_PORTS-1:0] o_mask
);

    localparam int AGE_W  = $clog2(STARVE_LIMIT + 1);
    localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [AGE_W-1:0] CREDIT_FULL = AGE_W'(STARVE_LIMIT);

    // Credit counts down per denied cycle; zero means the slot is starving.
    logic [AGE_W-1:0]     r_credit [NUM_PORTS];
    logic                 r_winner_valid;
    logic [PIDX_W-1:0]    r_winner;
    logic [NUM_PORTS-1:0] w_urgent;
    logic                 w_pick_valid;
    logic [PIDX_W-1:0]    w_pick;
    logic                 w_winner_done;

    always_comb begin
        w_urgent = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_urgent[i] = i_slot_valid[i] && (r_credit[i] == '0);
        end
    end

    // A port granted this cycle is being served, so it is not a candidate.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_urgent[i] && !i_grant[i]) begin
                w_pick_valid = 1'b1;
                w_pick       = PIDX_W'(i);
            end
        end
    end

    assign w_winner_done = !r_winner_valid || i_grant[r_winner];

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            o_mask[i] = r_winner_valid && (PIDX_W'(i) != r_winner)
                        && (i_bank[i] == i_bank[r_winner]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_credit[i] <= CREDIT_FULL;
            end
            r_winner_valid <= 1'b0;
            r_winner       <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (i_flush || !i_slot_valid[i] || i_grant[i]) begin
                    r_credit[i] <= CREDIT_FULL;
                end else if (r_credit[i] != '0) begin
                    r_credit[i] <= r_credit[i] - 1'b1;
                end
            end
            if (i_flush) begin
                r_winner_valid <= 1'b0;
            end else if (w_winner_done) begin
                r_winner_valid <= w_pick_valid;
                r_winner       <= w_pick;
            end
        end
    end

endmodule

// File: rtl/cache_port_scheduler.sv
// One-entry request slots per requester, issue to the banked port arbiter,
// and a 2-stage read-tag pipeline matching the arbiter's fixed read latency.
module cache_port_scheduler
    import cache_sched_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_port_scheduler_if.slave  bus
);

    logic [NUM_PORTS-1:0] w_slot_valid;
    logic [NUM_PORTS-1:0] w_mask;
    logic [NUM_PORTS-1:0] w_issue;
    logic [NUM_PORTS-1:0] w_grant;
    logic [NUM_PORTS-1:0] w_ready;
    logic [NUM_PORTS-1:0] w_accept;
    BankIdx               w_bank [NUM_PORTS];

    starve_select #(
        .NUM_PORTS    (NUM_PORTS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (bus.IN_flush),
        .i_slot_valid (w_slot_valid),
        .i_grant      (w_grant),
        .i_bank       (w_bank),
        .o_mask       (w_mask)
    );

    assign bus.OUT_reqReady = w_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        CacheReq_t            r_slot;
        logic                 r_s1_valid;
        logic                 r_s2_valid;
        logic [TAG_WIDTH-1:0] r_s1_tag;
        logic [TAG_WIDTH-1:0] r_s2_tag;

        assign w_slot_valid[i] = r_slot.valid;
        assign w_bank[i]       = bank_of(r_slot.addr);
        assign w_issue[i]      = r_slot.valid && !w_mask[i];
        assign w_grant[i]      = w_issue[i] && bus.IN_portReady[i];
        assign w_ready[i]      = !bus.IN_flush && (!r_slot.valid || w_grant[i]);
        assign w_accept[i]     = bus.IN_req[i].valid && w_ready[i];

        // Arbiter fields come only from the slot register, never from IN_req.
        assign bus.OUT_ports[i] = '{ce:    !w_issue[i],
                                    we:    r_slot.we,
                                    addr:  r_slot.addr,
                                    data:  r_slot.wdata,
                                    wmask: r_slot.wmask};

        assign bus.OUT_resp[i] = '{valid: r_s2_valid,
                                   tag:   r_s2_tag,
                                   data:  bus.IN_portRData[i]};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot     <= '0;
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
                r_s1_tag   <= '0;
                r_s2_tag   <= '0;
            end else begin
                if (w_accept[i]) begin
                    r_slot <= bus.IN_req[i];
                end else if (w_grant[i] || bus.IN_flush) begin
                    r_slot.valid <= 1'b0;
                end
                // Flush never cancels reads that have already been granted.
                r_s1_valid <= w_grant[i] && !r_slot.we;
                r_s1_tag   <= r_slot.tag;
                r_s2_valid <= r_s1_valid;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_cache_port_scheduler.sv
// Self-checking bench: behavioural arbiter, per-port response scoreboard,
// and cycle-indexed checks of issue, grant, masking, flush and reset.
module tb_cache_port_scheduler;
    import cache_sched_pkg::*;

    localparam int NP = 4;

    typedef struct {
        logic [3:0] tag;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    int      arb_mode;
    logic [NP-1:0] deny;
    logic [NP-1:0] arb_ready;
    logic [NP-1:0] arb_used;
    int      arb_n;
    logic [NP-1:0] ce_vec;
    logic [NP-1:0] grant_vec;
    logic [NP-1:0] resp_vec;

    exp_t sbq [NP][$];

    cache_port_scheduler_if #(.NUM_PORTS(NP)) bus ();

    cache_port_scheduler #(
        .NUM_PORTS    (NP),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input int p, input int c);
        return {8'(p), 8'hA5, 16'(c)};
    endfunction

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            ce_vec[p]   = bus.OUT_ports[p].ce;
            resp_vec[p] = bus.OUT_resp[p].valid;
        end
    end

    // Arbiter model: fixed priority 0>1>2>3, two physical ports, one grant per bank.
    always_comb begin
        arb_ready = '0;
        arb_used  = '0;
        arb_n     = 0;
        for (int p = 0; p < NP; p++) begin
            if (!ce_vec[p] && arb_n < 2 && !arb_used[bus.OUT_ports[p].addr[1:0]]) begin
                arb_ready[p] = 1'b1;
                arb_used[bus.OUT_ports[p].addr[1:0]] = 1'b1;
                arb_n = arb_n + 1;
            end
        end
    end

    always_comb begin
        bus.IN_portReady = (arb_mode == 1) ? arb_ready : ~deny;
        for (int p = 0; p < NP; p++) begin
            bus.IN_portRData[p] = rdata_of(p, cyc);
        end
    end

    assign grant_vec = ~ce_vec & bus.IN_portReady;

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    task automatic push_exp(input int p, input logic [3:0] tag, input int c);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        sbq[p].push_back(e);
    endtask

    task automatic set_req(input int p, input logic we, input logic [29:0] addr, input logic [3:0] tag);
        CacheReq_t r;
        r.valid = 1'b1;
        r.we    = we;
        r.addr  = addr;
        r.wdata = {2'b00, addr};
        r.wmask = '1;
        r.tag   = tag;
        bus.IN_req[p] = r;
    endtask

    task automatic clear_req();
        for (int p = 0; p < NP; p++) bus.IN_req[p] = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_sb_empty();
        for (int p = 0; p < NP; p++) check_val("sb_empty", 64'(sbq[p].size()), 64'd0);
    endtask

    // Response monitor: every resp pulse must match the head of its port's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                if (bus.OUT_resp[p].valid) begin
                    if (sbq[p].size() == 0) begin
                        check_val("resp_unexp", 64'(bus.OUT_resp[p].valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = sbq[p].pop_front();
                        check_val("resp_tag", 64'(bus.OUT_resp[p].tag), 64'(e.tag));
                        check_val("resp_cyc", 64'(cyc), 64'(e.cyc));
                        check_val("resp_data", 64'(bus.OUT_resp[p].data), 64'(rdata_of(p, e.cyc)));
                    end
                end
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        arb_mode     = 0;
        deny         = '0;
        rst_n        = 1'b0;
        bus.IN_flush = 1'b0;
        clear_req();
        repeat (3) next();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ce", 64'(ce_vec), 64'hF);
        check_val("rst_resp", 64'(resp_vec), 64'h0);
        check_val("rst_rdy", 64'(bus.OUT_reqReady), 64'hF);
        next();

        // Single read on port 0
        cyc = 0;
        for (int c = 0; c <= 6; c++) begin
            clear_req();
            if (c == 0) begin
                set_req(0, 1'b0, 30'h10, 4'd5);
                push_exp(0, 4'd5, 3);
            end
            @(negedge clk);
            if (c == 0) check_val("t1_rdy0", 64'(bus.OUT_reqReady[0]), 64'd1);
            if (c <= 3) begin
                check_val("t1_ce0", 64'(ce_vec[0]), 64'(c != 1));
                check_val("t1_gnt0", 64'(grant_vec[0]), 64'(c == 1));
            end
            next();
        end
        check_sb_empty();

        // Back-to-back stream on port 1
        cyc = 0;
        for (int c = 0; c <= 8; c++) begin
            clear_req();
            if (c < 4) begin
                set_req(1, 1'b0, 30'(32 + c), 4'(c));
                push_exp(1, 4'(c), c + 3);
            end
            @(negedge clk);
            if (c < 4) check_val("t2_rdy1", 64'(bus.OUT_reqReady[1]), 64'd1);
            next();
        end
        check_sb_empty();

        // Starvation: port 3 (bank 2) loses to port 0 (bank 2); port 1 (bank 1) unaffected
        cyc = 0;
        arb_mode = 1;
        for (int c = 0; c <= 18; c++) begin
            clear_req();
            if (c <= 13) begin
                set_req(0, 1'b1, 30'h102, 4'd0);
                set_req(1, 1'b1, 30'h101, 4'd0);
            end
            if (c == 0) begin
                set_req(3, 1'b0, 30'h302, 4'd9);
                push_exp(3, 4'd9, 12);
            end
            @(negedge clk);
            if (c >= 1 && c <= 13) begin
                check_val("st_ce0", 64'(ce_vec[0]), 64'(c == 10));
                check_val("st_ce1", 64'(ce_vec[1]), 64'd0);
                check_val("st_gnt1", 64'(grant_vec[1]), 64'd1);
            end
            if (c >= 1 && c <= 12) begin
                check_val("st_ce3", 64'(ce_vec[3]), 64'(c > 10));
                check_val("st_gnt3", 64'(grant_vec[3]), 64'(c == 10));
            end
            if (c == 18) check_val("st_idle_ce", 64'(ce_vec), 64'hF);
            next();
        end
        check_sb_empty();
        arb_mode = 0;

        // Flush with ports 0,2 held and denied; port 1 read granted in the flush cycle
        cyc = 0;
        deny = 4'b0101;
        for (int c = 0; c <= 5; c++) begin
            clear_req();
            bus.IN_flush = (c == 1);
            if (c == 0) begin
                set_req(0, 1'b0, 30'h40, 4'd1);
                set_req(1, 1'b0, 30'h41, 4'd7);
                set_req(2, 1'b0, 30'h42, 4'd2);
                push_exp(1, 4'd7, 3);
            end
            if (c == 1) set_req(3, 1'b1, 30'h43, 4'd0);
            @(negedge clk);
            if (c == 1) begin
                check_val("fl_rdy", 64'(bus.OUT_reqReady), 64'h0);
                check_val("fl_ce", 64'(ce_vec), 64'h8);
                check_val("fl_gnt", 64'(grant_vec), 64'h2);
            end
            if (c == 2) begin
                check_val("fl_after_ce", 64'(ce_vec), 64'hF);
                check_val("fl_after_rdy", 64'(bus.OUT_reqReady), 64'hF);
            end
            next();
        end
        bus.IN_flush = 1'b0;
        deny = '0;
        check_sb_empty();

        // Write on port 3 gives no response; reset while two reads are in flight
        cyc = 0;
        for (int c = 0; c <= 7; c++) begin
            clear_req();
            if (c == 0) set_req(3, 1'b1, 30'h33, 4'd3);
            if (c == 1) begin
                set_req(0, 1'b0, 30'h50, 4'd4);
                set_req(2, 1'b0, 30'h52, 4'd6);
            end
            if (c == 3) rst_n = 1'b0;
            if (c == 4) rst_n = 1'b1;
            @(negedge clk);
            check_val("rs_resp", 64'(resp_vec), 64'h0);
            if (c == 1) check_val("rs_wgnt", 64'(grant_vec), 64'h8);
            if (c == 2) check_val("rs_rgnt", 64'(grant_vec), 64'h5);
            if (c == 3 || c == 4) begin
                check_val("rs_ce", 64'(ce_vec), 64'hF);
                check_val("rs_rdy", 64'(bus.OUT_reqReady), 64'hF);
            end
            next();
        end
        check_sb_empty();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
